// File: rtl/mcif_read_ig_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mcif_read_ig_wrr_arb
// Purpose  : Weighted round-robin merge of MCIF read requests into one
//            registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mcif_read_ig_wrr_arb #(
  parameter int NUM_SRC = 10,
  parameter int PD_W    = 75,
  parameter int WT_W    = 8,
  parameter int ID_W    = 4
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rst,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic [NUM_SRC-1:0]        src_rdy,
  input  logic [NUM_SRC*PD_W-1:0]   src_pd,
  input  logic [NUM_SRC*WT_W-1:0]   reg2dp_rd_weight,
  output logic                      arb_out_vld,
  input  logic                      arb_out_rdy,
  output logic [PD_W-1:0]           arb_out_pd,
  output logic [ID_W-1:0]           arb_out_id
);

  localparam int CW = WT_W + 1;

  logic [NUM_SRC-1:0][CW-1:0] credit_q, credit_d;
  logic [ID_W-1:0]            last_gnt_q, last_gnt_d;
  logic                       out_vld_q, out_vld_d;
  logic [PD_W-1:0]            out_pd_q, out_pd_d;
  logic [ID_W-1:0]            out_id_q, out_id_d;

  logic [NUM_SRC-1:0]         elig;
  logic                       load;
  logic                       gnt_found;
  logic [ID_W-1:0]            gnt_idx;
  logic                       do_refill;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
    assign elig[gi] = src_vld[gi] && (credit_q[gi] != '0);
  end

  assign load      = !out_vld_q || arb_out_rdy;
  assign do_refill = load && !(|elig) && (|src_vld);

  // Search starts just after the last winner and wraps, giving round-robin order.
  always_comb begin : p_gnt
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_gnt_q) + k) % NUM_SRC;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    src_rdy = '0;
    if (load && gnt_found && !nvdla_core_rst) begin
      src_rdy = NUM_SRC'(1) << gnt_idx;
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_pd_d   = out_pd_q;
    out_id_d   = out_id_q;
    credit_d   = credit_q;
    last_gnt_d = last_gnt_q;
    if (load) begin
      out_vld_d = gnt_found;
      if (gnt_found) begin
        out_pd_d           = src_pd[gnt_idx*PD_W +: PD_W];
        out_id_d           = gnt_idx;
        credit_d[gnt_idx]  = credit_q[gnt_idx] - CW'(1);
        last_gnt_d         = gnt_idx;
      end
    end
    // Weight w yields w+1 grants per round, so a zero weight never starves.
    if (do_refill) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        credit_d[j] = CW'(reg2dp_rd_weight[j*WT_W +: WT_W]) + CW'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      out_vld_q  <= 1'b0;
      out_pd_q   <= '0;
      out_id_q   <= '0;
      credit_q   <= '0;
      last_gnt_q <= ID_W'(NUM_SRC - 1);
    end else begin
      out_vld_q  <= out_vld_d;
      out_pd_q   <= out_pd_d;
      out_id_q   <= out_id_d;
      credit_q   <= credit_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign arb_out_vld = out_vld_q;
  assign arb_out_pd  = out_pd_q;
  assign arb_out_id  = out_id_q;

endmodule
`default_nettype wire

// File: tb/tb_mcif_read_ig_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcif_read_ig_wrr_arb
// Purpose  : Directed self-checking bench for the MCIF read WRR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcif_read_ig_wrr_arb;

  localparam int NS = 10;
  localparam int PW = 75;
  localparam int WW = 8;
  localparam int IW = 4;

  logic               clk;
  logic               rst;
  logic [NS-1:0]      src_vld;
  logic [NS-1:0]      src_rdy;
  logic [NS*PW-1:0]   src_pd;
  logic [NS*WW-1:0]   wt;
  logic               out_vld;
  logic               out_rdy;
  logic [PW-1:0]      out_pd;
  logic [IW-1:0]      out_id;

  int checks   = 0;
  int failures = 0;

  mcif_read_ig_wrr_arb #(.NUM_SRC(NS), .PD_W(PW), .WT_W(WW), .ID_W(IW)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .src_vld          (src_vld),
    .src_rdy          (src_rdy),
    .src_pd           (src_pd),
    .reg2dp_rd_weight (wt),
    .arb_out_vld      (out_vld),
    .arb_out_rdy      (out_rdy),
    .arb_out_pd       (out_pd),
    .arb_out_id       (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pat(int i);
    logic [3:0] hi;
    logic [7:0] lo;
    hi = 4'(i);
    lo = 8'(i * 17 + 3);
    return {hi, 63'h0, lo};
  endfunction

  function automatic logic [NS-1:0] onehot(int e);
    logic [NS-1:0] one;
    one = 1;
    return (e < 0) ? '0 : (one << e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wt(int i, int w);
    logic [WW-1:0] v;
    v = WW'(w);
    wt[i*WW +: WW] = v;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    out_rdy = 1'b1;
    wt      = '0;
    src_vld = '0;
    for (int i = 0; i < NS; i++) src_pd[i*PW +: PW] = pat(i);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    out_rdy = 1'b1;
    wt      = '0;
    src_vld = '1;
    for (int i = 0; i < NS; i++) src_pd[i*PW +: PW] = pat(i);
    tick();
    tick();
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", out_vld); end
    checks++;
    if (out_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", out_id); end
    checks++;
    if (out_pd !== '0) begin failures++; $display("FAIL reset_pd got=%h exp=0", out_pd); end
    checks++;
    if (src_rdy !== '0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", src_rdy); end
  endtask

  // All weights zero, all sources valid: bubble, 0..9, bubble, 0..9.
  task automatic test_equal_rr();
    int e[23];
    apply_reset();
    e[0] = -1; e[1] = -1; e[12] = -1;
    for (int k = 0; k < NS; k++) begin e[2+k] = k; e[13+k] = k; end
    for (int c = 0; c < 23; c++) begin
      src_vld = 10'h3FF;
      #1;
      checks++;
      if (out_vld !== (e[c] >= 0)) begin failures++; $display("FAIL rr_vld c=%0d got=%0b exp=%0b", c, out_vld, e[c] >= 0); end
      if (e[c] >= 0) begin
        checks++;
        if (out_id !== IW'(e[c]) || out_pd !== pat(e[c])) begin
          failures++; $display("FAIL rr_data c=%0d got id=%0d pd=%h exp id=%0d pd=%h", c, out_id, out_pd, e[c], pat(e[c]));
        end
      end
      if (c < 22) begin
        checks++;
        if (src_rdy !== onehot(e[c+1])) begin failures++; $display("FAIL rr_rdy c=%0d got=%b exp=%b", c, src_rdy, onehot(e[c+1])); end
      end
      tick();
    end
  endtask

  // src0 weight 2, src3 weight 0: round 1 is 0,3,0,0; round 2 starts after 0 so 3,0,0,0.
  task automatic test_weighted();
    int e[12];
    apply_reset();
    set_wt(0, 2);
    set_wt(3, 0);
    e = '{-1, -1, 0, 3, 0, 0, -1, 3, 0, 0, 0, -1};
    for (int c = 0; c < 12; c++) begin
      src_vld = 10'h009;
      #1;
      checks++;
      if (out_vld !== (e[c] >= 0)) begin failures++; $display("FAIL wrr_vld c=%0d got=%0b exp=%0b", c, out_vld, e[c] >= 0); end
      if (e[c] >= 0) begin
        checks++;
        if (out_id !== IW'(e[c])) begin failures++; $display("FAIL wrr_id c=%0d got=%0d exp=%0d", c, out_id, e[c]); end
      end
      if (c < 11) begin
        checks++;
        if (src_rdy !== onehot(e[c+1])) begin failures++; $display("FAIL wrr_rdy c=%0d got=%b exp=%b", c, src_rdy, onehot(e[c+1])); end
      end
      tick();
    end
  endtask

  // Source 5, weight 3, downstream stalled for 4 cycles after the first valid.
  task automatic test_backpressure();
    int rdy_in[11];
    int pd_in[11];
    int exp_pd[11];
    int exp_rdy[11];
    apply_reset();
    set_wt(5, 3);
    rdy_in  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    pd_in   = '{100, 100, 101, 101, 101, 101, 101, 102, 103, 104, 104};
    exp_pd  = '{-1, -1, 100, 100, 100, 100, 100, 101, 102, 103, -1};
    exp_rdy = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    for (int c = 0; c < 11; c++) begin
      src_vld = onehot(5);
      out_rdy = (rdy_in[c] != 0);
      src_pd[5*PW +: PW] = PW'(pd_in[c]);
      #1;
      checks++;
      if (out_vld !== (exp_pd[c] >= 0)) begin failures++; $display("FAIL bp_vld c=%0d got=%0b exp=%0b", c, out_vld, exp_pd[c] >= 0); end
      if (exp_pd[c] >= 0) begin
        checks++;
        if (out_id !== IW'(5) || out_pd !== PW'(exp_pd[c])) begin
          failures++; $display("FAIL bp_data c=%0d got id=%0d pd=%0d exp id=5 pd=%0d", c, out_id, out_pd, exp_pd[c]);
        end
      end
      checks++;
      if (src_rdy !== (exp_rdy[c] != 0 ? onehot(5) : '0)) begin
        failures++; $display("FAIL bp_rdy c=%0d got=%b exp_src5=%0d", c, src_rdy, exp_rdy[c]);
      end
      tick();
    end
    out_rdy = 1'b1;
  endtask

  // src2 weight 1 then 4 after the first grant: 2 grants, bubble, 5 grants.
  task automatic test_weight_change();
    int e[11];
    apply_reset();
    set_wt(2, 1);
    e = '{-1, -1, 2, 2, -1, 2, 2, 2, 2, 2, -1};
    for (int c = 0; c < 11; c++) begin
      src_vld = onehot(2);
      if (c == 2) set_wt(2, 4);
      #1;
      checks++;
      if (out_vld !== (e[c] >= 0)) begin failures++; $display("FAIL wchg_vld c=%0d got=%0b exp=%0b", c, out_vld, e[c] >= 0); end
      if (c < 10) begin
        checks++;
        if (src_rdy !== onehot(e[c+1])) begin failures++; $display("FAIL wchg_rdy c=%0d got=%b exp=%b", c, src_rdy, onehot(e[c+1])); end
      end
      tick();
    end
  endtask

  // Source 1 drops valid when it would win; 4 wins, then 1 still has its credit.
  task automatic test_source_drop();
    int e[5];
    logic [NS-1:0] v[5];
    apply_reset();
    e = '{-1, -1, 4, 1, -1};
    v = '{10'h012, 10'h010, 10'h012, 10'h012, 10'h012};
    for (int c = 0; c < 5; c++) begin
      src_vld = v[c];
      #1;
      checks++;
      if (out_vld !== (e[c] >= 0)) begin failures++; $display("FAIL drop_vld c=%0d got=%0b exp=%0b", c, out_vld, e[c] >= 0); end
      if (e[c] >= 0) begin
        checks++;
        if (out_id !== IW'(e[c]) || out_pd !== pat(e[c])) begin
          failures++; $display("FAIL drop_data c=%0d got id=%0d exp id=%0d", c, out_id, e[c]);
        end
      end
      if (c < 4) begin
        checks++;
        if (src_rdy !== onehot(e[c+1])) begin failures++; $display("FAIL drop_rdy c=%0d got=%b exp=%b", c, src_rdy, onehot(e[c+1])); end
      end
      tick();
    end
  endtask

  // Reset during a stall discards the held output; source 0 is served first afterwards.
  task automatic test_reset_in_stall();
    apply_reset();
    src_vld = 10'h3FF;
    tick();
    tick();
    out_rdy = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b1 || out_id !== '0) begin failures++; $display("FAIL rst_stall_pre got vld=%0b id=%0d exp vld=1 id=0", out_vld, out_id); end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (src_rdy !== '0) begin failures++; $display("FAIL rst_stall_rdy got=%b exp=0", src_rdy); end
    tick();
    checks++;
    if (out_vld !== 1'b0 || out_pd !== '0 || out_id !== '0) begin
      failures++; $display("FAIL rst_stall_clear got vld=%0b id=%0d pd=%h exp all 0", out_vld, out_id, out_pd);
    end
    rst     = 1'b0;
    out_rdy = 1'b1;
    tick();
    checks++;
    if (out_vld !== 1'b0 || src_rdy !== onehot(0)) begin
      failures++; $display("FAIL rst_stall_bubble got vld=%0b rdy=%b exp vld=0 rdy=%b", out_vld, src_rdy, onehot(0));
    end
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_id !== '0 || out_pd !== pat(0)) begin
      failures++; $display("FAIL rst_stall_first got vld=%0b id=%0d exp vld=1 id=0", out_vld, out_id);
    end
  endtask

  initial begin
    rst     = 1'b1;
    src_vld = '0;
    src_pd  = '0;
    wt      = '0;
    out_rdy = 1'b1;
    test_reset();
    test_equal_rr();
    test_weighted();
    test_backpressure();
    test_weight_change();
    test_source_drop();
    test_reset_in_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
